fwvexrisc_wb_timer: RTL and testbench

Wishbone target peripheral that generates the core's `irq` input: a RISC-V-style 64-bit `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp` compare register. It sits on the core's data bus beside `fw_wishbone_sram_ctrl_single`, behind an upstream address decoder. Its `irq` output drives the `irq` input of `fwvexrisc_rv32i_wb`.

---
 rtl/fwvexrisc_wb_timer.sv | 203 ++++++++++++++++++++
 tb/tb_fwvexrisc_wb_timer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwvexrisc_wb_timer.sv
// Wishbone timer peripheral: 64-bit mtime with prescaler, 64-bit mtimecmp and a level irq.
// Single-cycle registered response with an atomic hi-word shadow for 64-bit reads.
module fwvexrisc_wb_timer #(
    parameter int          ADR_WIDTH      = 32,
    parameter int          DAT_WIDTH      = 32,
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADR_WIDTH-1:0] t_adr,
    input  logic [DAT_WIDTH-1:0] t_dat_w,
    output logic [DAT_WIDTH-1:0] t_dat_r,
    input  logic                 t_cyc,
    input  logic                 t_stb,
    input  logic                 t_we,
    input  logic [3:0]           t_sel,
    output logic                 t_ack,
    output logic                 t_err,
    output logic                 irq
);

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } bus_state_e;

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4,
        REG_PRESCALE    = 3'd5,
        REG_STATUS      = 3'd6,
        REG_UNMAPPED    = 3'd7
    } reg_e;

    typedef struct packed {
        logic irq_en;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wr_word,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = wr_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    bus_state_e  state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_r_q, dat_r_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic        irq_q, irq_d;

    reg_e        reg_sel;
    logic        req;
    logic        access;
    logic        wr_en;
    logic        tick;
    logic        pend;
    logic [31:0] rdata;
    logic [31:0] wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
    logic        unused_adr_bits;

    assign reg_sel = reg_e'(t_adr[4:2]);
    assign req     = t_cyc & t_stb;
    assign access  = (state_q == ST_IDLE) & req;
    assign wr_en   = access & t_we;
    assign tick    = ctrl_q.en & (pcnt_q == prescale_q);
    assign pend    = (mtime_q >= mtimecmp_q);

    assign unused_adr_bits = ^{t_adr[ADR_WIDTH-1:5], t_adr[1:0]};

    assign wr_mtime_lo = merge_bytes(mtime_q[31:0],     t_dat_w, t_sel);
    assign wr_mtime_hi = merge_bytes(mtime_q[63:32],    t_dat_w, t_sel);
    assign wr_cmp_lo   = merge_bytes(mtimecmp_q[31:0],  t_dat_w, t_sel);
    assign wr_cmp_hi   = merge_bytes(mtimecmp_q[63:32], t_dat_w, t_sel);

    // Read data reflects register state before the current edge.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_MTIME_LO:    rdata = mtime_q[31:0];
            REG_MTIME_HI:    rdata = shadow_q;
            REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            REG_CTRL:        rdata[1:0] = ctrl_q;
            REG_PRESCALE:    rdata[15:0] = prescale_q;
            REG_STATUS:      rdata[0] = pend;
            default:         rdata = '0;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_r_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_RESP;
                    ack_d   = (reg_sel != REG_UNMAPPED);
                    err_d   = (reg_sel == REG_UNMAPPED);
                    dat_r_d = rdata;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        shadow_d   = shadow_q;
        pcnt_d     = pcnt_q;

        if (ctrl_q.en) begin
            pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
        end

        if (access && !t_we && reg_sel == REG_MTIME_LO) begin
            shadow_d = mtime_q[63:32];
        end

        // A write to either mtime half replaces the whole next value, dropping that cycle's tick.
        if (wr_en) begin
            case (reg_sel)
                REG_MTIME_LO:    mtime_d = {mtime_q[63:32], wr_mtime_lo};
                REG_MTIME_HI:    mtime_d = {wr_mtime_hi, mtime_q[31:0]};
                REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wr_cmp_lo};
                REG_MTIMECMP_HI: mtimecmp_d = {wr_cmp_hi, mtimecmp_q[31:0]};
                REG_CTRL: begin
                    if (t_sel[0]) begin
                        ctrl_d = ctrl_t'(t_dat_w[1:0]);
                    end
                end
                REG_PRESCALE: begin
                    if (t_sel[0]) prescale_d[7:0]  = t_dat_w[7:0];
                    if (t_sel[1]) prescale_d[15:8] = t_dat_w[15:8];
                    pcnt_d = 16'd0;
                end
                default: ;
            endcase
        end

        irq_d = ctrl_q.irq_en & pend;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_r_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ctrl_q     <= '0;
            prescale_q <= PRESCALE_RESET;
            pcnt_q     <= '0;
            shadow_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_r_q    <= dat_r_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            shadow_q   <= shadow_d;
            irq_q      <= irq_d;
        end
    end

    assign t_ack   = ack_q;
    assign t_err   = err_q;
    assign t_dat_r = dat_r_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_fwvexrisc_wb_timer.sv
// Scoreboard bench for fwvexrisc_wb_timer: bus tasks queue expected responses,
// a monitor pops and compares them whenever the DUT acks or errors.
module tb_fwvexrisc_wb_timer;

    localparam int R_MTIME_LO = 0;
    localparam int R_MTIME_HI = 1;
    localparam int R_CMP_LO   = 2;
    localparam int R_CMP_HI   = 3;
    localparam int R_CTRL     = 4;
    localparam int R_PRESCALE = 5;
    localparam int R_STATUS   = 6;
    localparam int R_UNMAPPED = 7;

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] t_adr = '0;
    logic [31:0] t_dat_w = '0;
    logic [31:0] t_dat_r;
    logic        t_cyc = 1'b0;
    logic        t_stb = 1'b0;
    logic        t_we = 1'b0;
    logic [3:0]  t_sel = '0;
    logic        t_ack;
    logic        t_err;
    logic        irq;

    int    n_vec  = 0;
    int    n_miss = 0;
    int    n_resp = 0;
    exp_t  sb_q[$];
    string name_q[$];

    fwvexrisc_wb_timer #(
        .ADR_WIDTH(32),
        .DAT_WIDTH(32),
        .PRESCALE_RESET(16'd0)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .t_adr  (t_adr),
        .t_dat_w(t_dat_w),
        .t_dat_r(t_dat_r),
        .t_cyc  (t_cyc),
        .t_stb  (t_stb),
        .t_we   (t_we),
        .t_sel  (t_sel),
        .t_ack  (t_ack),
        .t_err  (t_err),
        .irq    (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest queued expectation and never follow another.
    initial begin
        logic  prev_resp;
        exp_t  e;
        string nm;
        prev_resp = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_resp = 1'b0;
            end else begin
                if (t_ack || t_err) begin
                    n_resp++;
                    check("response spacing", {63'd0, prev_resp}, 64'd0);
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected response: ack=%b err=%b dat=%h", t_ack, t_err, t_dat_r);
                    end else begin
                        e  = sb_q.pop_front();
                        nm = name_q.pop_front();
                        check({nm, " term"}, {62'd0, t_err, t_ack}, {62'd0, e.err, ~e.err});
                        if (e.chk) check({nm, " data"}, {32'd0, t_dat_r}, {32'd0, e.dat});
                    end
                end
                prev_resp = t_ack | t_err;
            end
        end
    end

    task automatic issue(input logic we, input int idx, input logic [31:0] dat, input logic [3:0] sel,
                         input logic chk, input logic [31:0] exp_dat, input logic exp_err, input string nm);
        exp_t e;
        @(negedge clock);
        t_adr   = {27'd0, 3'(idx), 2'b00};
        t_we    = we;
        t_dat_w = dat;
        t_sel   = sel;
        t_cyc   = 1'b1;
        t_stb   = 1'b1;
        e.err   = exp_err;
        e.chk   = chk;
        e.dat   = exp_dat;
        sb_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clock);
        #1;
        t_cyc = 1'b0;
        t_stb = 1'b0;
        t_we  = 1'b0;
    endtask

    task automatic finish_resp(input string nm);
        @(negedge clock);
        check({nm, " latency"}, {63'd0, t_ack | t_err}, 64'd1);
        @(posedge clock);
    endtask

    task automatic wr_sel(input int idx, input logic [31:0] dat, input logic [3:0] sel);
        string nm;
        nm = $sformatf("wr r%0d", idx);
        issue(1'b1, idx, dat, sel, 1'b0, 32'd0, 1'b0, nm);
        finish_resp(nm);
    endtask

    task automatic wr(input int idx, input logic [31:0] dat);
        wr_sel(idx, dat, 4'hF);
    endtask

    task automatic rd(input int idx, input logic [31:0] exp_dat, input string nm);
        issue(1'b0, idx, 32'd0, 4'hF, 1'b1, exp_dat, 1'b0, nm);
        finish_resp(nm);
    endtask

    initial begin
        int n0;
        #2;
        check("reset ack", {63'd0, t_ack}, 64'd0);
        check("reset err", {63'd0, t_err}, 64'd0);
        check("reset irq", {63'd0, irq}, 64'd0);
        check("reset dat_r", {32'd0, t_dat_r}, 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        rd(R_CTRL, 32'd0, "ctrl after reset");
        rd(R_CMP_LO, 32'hFFFF_FFFF, "cmp_lo after reset");
        rd(R_CMP_HI, 32'hFFFF_FFFF, "cmp_hi after reset");
        rd(R_PRESCALE, 32'd0, "prescale after reset");
        rd(R_MTIME_LO, 32'd0, "mtime_lo after reset");
        rd(R_STATUS, 32'd0, "status after reset");

        // Raise irq, then reset asynchronously in the middle of an ack cycle.
        wr(R_CMP_HI, 32'd0);
        wr(R_CMP_LO, 32'd0);
        wr(R_CTRL, 32'd2);
        #1;
        check("irq at mtime>=cmp", {63'd0, irq}, 64'd1);
        @(negedge clock);
        t_adr = {27'd0, 3'(R_CTRL), 2'b00};
        t_we  = 1'b0;
        t_sel = 4'hF;
        t_cyc = 1'b1;
        t_stb = 1'b1;
        @(posedge clock);
        #2;
        check("ack before async reset", {63'd0, t_ack}, 64'd1);
        check("dat_r before async reset", {32'd0, t_dat_r}, 64'd2);
        reset = 1'b1;
        #1;
        check("ack dropped by reset", {63'd0, t_ack}, 64'd0);
        check("dat_r cleared by reset", {32'd0, t_dat_r}, 64'd0);
        check("irq cleared by reset", {63'd0, irq}, 64'd0);
        check("err after reset", {63'd0, t_err}, 64'd0);
        t_cyc = 1'b0;
        t_stb = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        rd(R_CMP_LO, 32'hFFFF_FFFF, "cmp_lo after async reset");
        rd(R_CMP_HI, 32'hFFFF_FFFF, "cmp_hi after async reset");
        rd(R_CTRL, 32'd0, "ctrl after async reset");

        // PRESCALE=3: EN for 40 counting edges yields 10 ticks.
        wr(R_PRESCALE, 32'd3);
        wr(R_CTRL, 32'd1);
        repeat (38) @(posedge clock);
        wr(R_CTRL, 32'd0);
        rd(R_MTIME_LO, 32'd10, "prescale 3 rate");
        rd(R_PRESCALE, 32'd3, "prescale readback");

        // PRESCALE=0: 10 counting edges yield 10 ticks.
        wr(R_PRESCALE, 32'd0);
        wr(R_MTIME_LO, 32'd0);
        wr(R_CTRL, 32'd1);
        repeat (8) @(posedge clock);
        wr(R_CTRL, 32'd0);
        rd(R_MTIME_LO, 32'd10, "prescale 0 rate");

        // irq rises one cycle after mtime reaches 20.
        wr(R_MTIME_LO, 32'd0);
        wr(R_CMP_HI, 32'd0);
        wr(R_CMP_LO, 32'd20);
        wr(R_CTRL, 32'd3);
        repeat (19) @(posedge clock);
        #1;
        check("irq low while mtime=20 not yet seen", {63'd0, irq}, 64'd0);
        @(posedge clock);
        #1;
        check("irq high one cycle after mtime=20", {63'd0, irq}, 64'd1);
        issue(1'b1, R_CMP_LO, 32'd1000, 4'hF, 1'b0, 32'd0, 1'b0, "wr cmp_lo 1000");
        check("irq holds on cmp write edge", {63'd0, irq}, 64'd1);
        finish_resp("wr cmp_lo 1000");
        #1;
        check("irq falls after cmp raised", {63'd0, irq}, 64'd0);
        wr(R_CTRL, 32'd0);
        rd(R_STATUS, 32'd0, "status below cmp");

        // Carry: LO read before the carry latches shadow 0; HI read later returns it.
        wr(R_MTIME_LO, 32'hFFFF_FFF0);
        wr(R_MTIME_HI, 32'd0);
        wr(R_CTRL, 32'd1);
        repeat (5) @(posedge clock);
        rd(R_MTIME_LO, 32'hFFFF_FFF6, "lo before carry");
        repeat (20) @(posedge clock);
        rd(R_MTIME_HI, 32'd0, "hi returns shadow");
        wr(R_CTRL, 32'd0);
        rd(R_MTIME_LO, 32'h0000_000F, "lo after carry");
        rd(R_MTIME_HI, 32'd1, "hi after carry");

        // 64-bit wrap: all-ones plus two ticks.
        wr(R_MTIME_LO, 32'hFFFF_FFFF);
        wr(R_MTIME_HI, 32'hFFFF_FFFF);
        wr(R_CTRL, 32'd1);
        wr(R_CTRL, 32'd0);
        rd(R_MTIME_LO, 32'd1, "wrap lo");
        rd(R_MTIME_HI, 32'd0, "wrap hi");

        // Writes on tick cycles take the written value and suppress that increment.
        wr(R_CTRL, 32'd1);
        wr(R_MTIME_LO, 32'h55);
        wr(R_CTRL, 32'd0);
        rd(R_MTIME_LO, 32'h57, "lo write on tick");
        wr(R_MTIME_LO, 32'h100);
        wr(R_CTRL, 32'd1);
        wr(R_MTIME_HI, 32'd7);
        wr(R_CTRL, 32'd0);
        rd(R_MTIME_LO, 32'h103, "hi write suppresses tick");
        rd(R_MTIME_HI, 32'd7, "hi write on tick");

        // Byte lanes.
        wr(R_CMP_LO, 32'hFFFF_FFFF);
        wr_sel(R_CMP_LO, 32'hAABB_CCDD, 4'b0101);
        rd(R_CMP_LO, 32'hFFBB_FFDD, "byte lanes 0101");
        wr_sel(R_CMP_LO, 32'h1234_5678, 4'b0000);
        rd(R_CMP_LO, 32'hFFBB_FFDD, "sel 0 writes nothing");

        // STATUS follows the 64-bit compare and ignores writes.
        rd(R_STATUS, 32'd1, "status pend hi>cmp_hi");
        wr(R_CMP_HI, 32'd8);
        rd(R_STATUS, 32'd0, "status clear");
        wr(R_STATUS, 32'd1);
        rd(R_STATUS, 32'd0, "status write ignored");

        // Unmapped offset 0x1C.
        issue(1'b0, R_UNMAPPED, 32'd0, 4'hF, 1'b1, 32'd0, 1'b1, "rd unmapped");
        finish_resp("rd unmapped");
        issue(1'b1, R_UNMAPPED, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0, 1'b1, "wr unmapped");
        finish_resp("wr unmapped");
        rd(R_CTRL, 32'd0, "ctrl after unmapped write");
        rd(R_CMP_HI, 32'd8, "cmp_hi after unmapped write");
        rd(R_PRESCALE, 32'd0, "prescale after unmapped write");

        // Held strobe: accepted every other edge.
        wr(R_PRESCALE, 32'hDEAD_1234);
        n0 = n_resp;
        @(negedge clock);
        t_adr = {27'd0, 3'(R_PRESCALE), 2'b00};
        t_we  = 1'b0;
        t_sel = 4'hF;
        t_cyc = 1'b1;
        t_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.err = 1'b0;
            e.chk = 1'b1;
            e.dat = 32'h0000_1234;
            sb_q.push_back(e);
            name_q.push_back($sformatf("held rd %0d", i));
        end
        repeat (8) @(posedge clock);
        #1;
        t_cyc = 1'b0;
        t_stb = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("held strobe ack count", 64'(n_resp - n0), 64'd4);

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
